// File: rtl/npu_dma_pkg.sv
// Shared definitions for the NPU scratch-SRAM DMA engines.
// Covers the engine state encoding and the scratch SRAM geometry.
package npu_dma_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_DEPTH  = 4096;
  localparam int CMD_LEN_W   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/sram_vector_streamer_if.sv
// Command, SRAM port-2 and operand-stream signals of the vector streamer.
// The master side is the streamer; the slave side is its environment.
interface sram_vector_streamer_if
  import npu_dma_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = CMD_LEN_W
);
  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_base;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_stride;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] sram_address;
  logic              sram_chipselect;
  logic              sram_write;
  logic [DATA_W-1:0] sram_writedata;
  logic [1:0]        sram_byteenable;
  logic              sram_clken;
  logic [DATA_W-1:0] sram_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    input  cmd_start, cmd_base, cmd_len, cmd_stride, sram_readdata, out_ready,
    output busy, done, sram_address, sram_chipselect, sram_write,
           sram_writedata, sram_byteenable, sram_clken,
           out_data, out_valid, out_last
  );

  modport slave (
    output cmd_start, cmd_base, cmd_len, cmd_stride, sram_readdata, out_ready,
    input  busy, done, sram_address, sram_chipselect, sram_write,
           sram_writedata, sram_byteenable, sram_clken,
           out_data, out_valid, out_last
  );
endinterface

// File: rtl/npu_skid_fifo2.sv
// Two-entry valid/ready FIFO; the head entry drives the output directly,
// so out_valid is purely registered and never depends on out_ready.
module npu_skid_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       push;
  logic       pop;
  logic [W-1:0] entry_data [2];

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic SLOT = (gi == 1);
      logic [W-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == SLOT)) begin
          entry_reg <= in_data;
        end
      end
      assign entry_data[gi] = entry_reg;
    end
  endgenerate

  assign out_data = entry_data[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/sram_vector_streamer.sv
// Read-side DMA: turns a (base, length, stride) command into a stream of
// SRAM words with a last marker, throttled so the 2-entry skid FIFO never overflows.
module sram_vector_streamer
  import npu_dma_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int LEN_W  = CMD_LEN_W
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_vector_streamer_if.master bus
);
  dma_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] stride_reg;
  logic [LEN_W-1:0]  remain_reg;
  logic              inflight_reg;
  logic              inflight_last_reg;

  logic              fifo_in_ready;
  logic              fifo_out_valid;
  logic [DATA_W:0]   fifo_out_data;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        occupancy;
  logic              issue;
  logic              last_issue;
  logic              drained;
  logic              accept;

  assign pop    = fifo_out_valid & bus.out_ready;
  assign accept = (state_reg == IDLE) & bus.cmd_start;
  // Words held plus the read in flight, minus the word leaving this cycle.
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue      = (state_reg == RUN) && (occupancy < 3'd2);
  assign last_issue = issue && (remain_reg == LEN_W'(1));
  assign drained    = !inflight_reg && (fifo_count == {1'b0, pop});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_start) begin
          state_next = (bus.cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN:     if (last_issue) state_next = DRAIN;
      DRAIN:   if (drained) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      addr_reg          <= '0;
      stride_reg        <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      inflight_reg      <= issue;
      inflight_last_reg <= last_issue;
      if (accept) begin
        addr_reg   <= bus.cmd_base;
        stride_reg <= bus.cmd_stride;
        remain_reg <= bus.cmd_len;
      end else if (issue) begin
        addr_reg   <= addr_reg + stride_reg;
        remain_reg <= remain_reg - LEN_W'(1);
      end
    end
  end

  npu_skid_fifo2 #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inflight_reg & fifo_in_ready),
    .in_ready  (fifo_in_ready),
    .in_data   ({inflight_last_reg, bus.sram_readdata}),
    .out_valid (fifo_out_valid),
    .out_ready (bus.out_ready),
    .out_data  (fifo_out_data),
    .count     (fifo_count)
  );

  assign bus.busy            = (state_reg != IDLE);
  assign bus.done            = (state_reg == DONE);
  assign bus.sram_address    = addr_reg;
  assign bus.sram_chipselect = issue;
  assign bus.sram_write      = 1'b0;
  assign bus.sram_writedata  = '0;
  assign bus.sram_byteenable = 2'b11;
  assign bus.sram_clken      = 1'b1;
  assign bus.out_valid       = fifo_out_valid;
  assign bus.out_data        = fifo_out_data[DATA_W-1:0];
  assign bus.out_last        = fifo_out_data[DATA_W];
endmodule

// File: tb/tb_sram_vector_streamer.sv
// Directed bench for sram_vector_streamer against a behavioural SRAM whose
// word i holds 0x1000 + i.
module tb_sram_vector_streamer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [15:0] mem [0:4095];

  logic [15:0] got_data [$];
  logic        got_last [$];
  logic [11:0] got_addr [$];
  int first_valid, first_hs, last_hs, done_win, done_cnt;
  int stall_bad, max_occ, valid_cnt;

  sram_vector_streamer_if bus ();

  sram_vector_streamer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.sram_chipselect) bus.sram_readdata <= mem[bus.sram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] last_mask();
    logic [7:0] m;
    m = '0;
    foreach (got_last[i]) if (i < 8) m[i] = got_last[i];
    return m;
  endfunction

  task automatic start_cmd(input logic [11:0] base, input logic [12:0] len, input logic [11:0] stride);
    bus.cmd_base   = base;
    bus.cmd_len    = len;
    bus.cmd_stride = stride;
    bus.cmd_start  = 1'b1;
    @(posedge clk); #1;
    bus.cmd_start  = 1'b0;
  endtask

  // Window k is the cycle after the k-th edge following the start edge.
  task automatic collect(input int budget, input logic [3:0] pat, input int retry_at);
    int cs_cnt, prev_cs, pops, occ;
    logic prev_stall, prev_last;
    logic [15:0] prev_data;
    got_data.delete(); got_last.delete(); got_addr.delete();
    first_valid = -1; first_hs = -1; last_hs = -1; done_win = -1; done_cnt = 0;
    stall_bad = 0; max_occ = 0; valid_cnt = 0;
    cs_cnt = 0; prev_cs = 0; pops = 0;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    for (int k = 0; k < budget; k++) begin
      bus.out_ready = pat[k % 4];
      bus.cmd_start = (k == retry_at);
      #1;
      occ = cs_cnt - prev_cs - pops;
      if (occ > max_occ) max_occ = occ;
      if (bus.sram_chipselect) got_addr.push_back(bus.sram_address);
      if (bus.out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = k;
      end
      if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last))
        stall_bad++;
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        if (first_hs < 0) first_hs = k;
        last_hs = k;
        pops++;
      end
      if (bus.done) begin
        done_cnt++;
        done_win = k;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      prev_cs    = bus.sram_chipselect ? 1 : 0;
      cs_cnt    += prev_cs;
      if (done_win >= 0 && k >= done_win + 2) break;
      @(posedge clk); #1;
    end
    bus.cmd_start = 1'b0;
    bus.out_ready = 1'b1;
    $display("cmd words=%0d reads=%0d first_valid=%0d last_hs=%0d done_win=%0d done_cnt=%0d",
             got_data.size(), got_addr.size(), first_valid, last_hs, done_win, done_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
    reset = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_base = '0;
    bus.cmd_len = '0;
    bus.cmd_stride = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_cs", bus.sram_chipselect, 0);
    check("rst_addr", bus.sram_address, 0);
    check("tie_write", bus.sram_write, 0);
    check("tie_be", bus.sram_byteenable, 2'b11);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic read
    start_cmd(12'h010, 13'd4, 12'd1);
    check("basic_busy", bus.busy, 1);
    collect(40, 4'b1111, -1);
    check("basic_count", got_data.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("basic_data%0d", i), got_data[i], 32'h1010 + i);
    check("basic_last", last_mask(), 8'h08);
    check("basic_first_valid", first_valid, 2);
    check("basic_first_hs", first_hs, 2);
    check("basic_last_hs", last_hs, 5);
    check("basic_done_win", done_win, 6);
    check("basic_done_cnt", done_cnt, 1);

    // Backpressure: ready 1,0,0,1 repeating
    start_cmd(12'h100, 13'd8, 12'd1);
    collect(200, 4'b1001, -1);
    check("bp_count", got_data.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("bp_data%0d", i), got_data[i], 32'h1100 + i);
    check("bp_last", last_mask(), 8'h80);
    check("bp_stall_stable", stall_bad, 0);
    check("bp_occ_le2", (max_occ <= 2), 1);
    check("bp_done_after_hs", done_win, last_hs + 1);
    check("bp_done_cnt", done_cnt, 1);

    // Wrap and stride
    start_cmd(12'hFFE, 13'd4, 12'd3);
    collect(40, 4'b1111, -1);
    check("wrap_reads", got_addr.size(), 4);
    check("wrap_addr0", got_addr[0], 12'hFFE);
    check("wrap_addr1", got_addr[1], 12'h001);
    check("wrap_addr2", got_addr[2], 12'h004);
    check("wrap_addr3", got_addr[3], 12'h007);
    check("wrap_data0", got_data[0], 16'h1FFE);
    check("wrap_data1", got_data[1], 16'h1001);
    check("wrap_data2", got_data[2], 16'h1004);
    check("wrap_data3", got_data[3], 16'h1007);
    check("wrap_last", last_mask(), 8'h08);

    // Zero length
    start_cmd(12'h050, 13'd0, 12'd1);
    collect(20, 4'b1111, -1);
    check("zero_reads", got_addr.size(), 0);
    check("zero_valid", valid_cnt, 0);
    check("zero_done_win", done_win, 0);
    check("zero_done_cnt", done_cnt, 1);

    // Start while busy: the retried command would change base and length
    start_cmd(12'h200, 13'd6, 12'd2);
    bus.cmd_base = 12'h300;
    bus.cmd_len  = 13'd2;
    collect(60, 4'b1111, 3);
    check("busy_count", got_data.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("busy_data%0d", i), got_data[i], 32'h1200 + 2 * i);
    check("busy_last", last_mask(), 8'h20);
    check("busy_done_cnt", done_cnt, 1);

    // Reset mid-command with one word held and one read in flight
    bus.out_ready = 1'b0;
    start_cmd(12'h400, 13'd8, 12'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_pre_valid", bus.out_valid, 1);
    check("midrst_pre_busy", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_cs", bus.sram_chipselect, 0);
    @(posedge clk); #1;
    check("midrst_valid2", bus.out_valid, 0);
    check("midrst_done2", bus.done, 0);
    bus.out_ready = 1'b1;
    start_cmd(12'h020, 13'd3, 12'd1);
    collect(40, 4'b1111, -1);
    check("post_count", got_data.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("post_data%0d", i), got_data[i], 32'h1020 + i);
    check("post_last", last_mask(), 8'h04);
    check("post_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
